carry_chain_sequencer: RTL

Multi-cycle add/subtract controller that time-shares one narrow FLE carry-chain slice across a wide operand. It accepts two DATA_WIDTH operands through a valid/ready handshake and sequences them through a SLICE_WIDTH-bit ripple slice, least-significant slice first. The carry-out of each pass is registered and fed back as the next pass's carry-in. It sits between fabric logic that needs occasional wide arithmetic and the carry resources, trading latency for chain length.

---
 rtl/carry_seq_pkg.sv | 23 ++
 rtl/carry_slice.sv | 30 +++
 rtl/carry_chain_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/carry_seq_pkg.sv
// Shared definitions for the carry-chain sequencer: state encoding, pass count
// and the operand/slice width compatibility check.
package carry_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } seq_state_e;

  function automatic int num_passes(input int data_w, input int slice_w);
    return data_w / slice_w;
  endfunction

  function automatic bit slice_cfg_ok(input int data_w, input int slice_w);
    return (slice_w >= 1) && (slice_w <= data_w) && ((data_w % slice_w) == 0);
  endfunction

endpackage

// File: rtl/carry_slice.sv
// Combinational WIDTH-bit ripple adder slice built from per-bit propagate/generate
// carry cells; also exposes the carry into the MSB for signed-overflow detection.
module carry_slice #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] o,
  output logic             cout,
  output logic             c_msb_in
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic p;
    logic g;
    assign p      = a[i] ^ b[i];
    assign g      = a[i] & b[i];
    assign o[i]   = p ^ c[i];
    assign c[i+1] = p ? c[i] : g;
  end

  assign cout     = c[WIDTH];
  assign c_msb_in = c[WIDTH-1];

endmodule

// File: rtl/carry_chain_sequencer.sv
// Wide add/subtract that reuses one SLICE_WIDTH ripple slice over N passes,
// LSB slice first, with the inter-pass carry held in a register.
module carry_chain_sequencer
  import carry_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SLICE_WIDTH = 8
) (
  input  logic                  C,
  input  logic                  R,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  SUB,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [DATA_WIDTH-1:0] SUM,
  output logic                  COUT,
  output logic                  OVF,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY
);

  localparam int N  = num_passes(DATA_WIDTH, SLICE_WIDTH);
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  if (!slice_cfg_ok(DATA_WIDTH, SLICE_WIDTH)) begin : g_cfg_check
    $fatal(1, "DATA_WIDTH must be a positive multiple of SLICE_WIDTH");
  end

  seq_state_e            state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic                  carry_q, carry_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  cout_q, cout_d;
  logic                  ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0]  opa_sh;
  logic [DATA_WIDTH-1:0]  opb_sh;
  logic [SLICE_WIDTH-1:0] slice_a;
  logic [SLICE_WIDTH-1:0] slice_b;
  logic [SLICE_WIDTH-1:0] slice_o;
  logic                   slice_cout;
  logic                   slice_c_msb;

  // Select the active slice of each operand by shifting it down to bit 0.
  assign opa_sh  = opa_q >> (int'(k_q) * SLICE_WIDTH);
  assign opb_sh  = opb_q >> (int'(k_q) * SLICE_WIDTH);
  assign slice_a = opa_sh[SLICE_WIDTH-1:0];
  assign slice_b = opb_sh[SLICE_WIDTH-1:0];

  carry_slice #(
    .WIDTH(SLICE_WIDTH)
  ) u_slice (
    .a        (slice_a),
    .b        (slice_b),
    .cin      (carry_q),
    .o        (slice_o),
    .cout     (slice_cout),
    .c_msb_in (slice_c_msb)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          opa_d   = A;
          opb_d   = SUB ? ~B : B;
          carry_d = SUB;
          k_d     = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (k_q == KW'(i)) sum_d[i*SLICE_WIDTH +: SLICE_WIDTH] = slice_o;
        end
        carry_d = slice_cout;
        if (k_q == KW'(N - 1)) begin
          cout_d  = slice_cout;
          ovf_d   = slice_c_msb ^ slice_cout;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q <= IDLE;
      k_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result is only presented in DONE; during RUN SUM holds a partial value,
  // but OUT_VALID gates it.
  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign SUM       = sum_q;
  assign COUT      = cout_q;
  assign OVF       = ovf_q;

endmodule
